ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Multi-cycle EX-stage multiply/divide unit for the 32-bit MIPS pipeline.
- Consumes operands and an op code from the ID_EX pipeline register outputs and computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers.
- Holds the front of the pipeline via stall_out while it iterates.
- Also services MTHI/MTLO writes; HI/LO are read combinationally by the EX-stage result mux for MFHI/MFLO.

Parameters:
- DATA_W, 32, operand/HI/LO width. Iteration count equals DATA_W.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_in  input  1  ID_EX says a mul/div op is in EX this cycle.
- op_in  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- Read_Data_1_in  input  DATA_W  rs operand (multiplicand/dividend; MTHI/MTLO source).
- Read_Data_2_in  input  DATA_W  rt operand (multiplier/divisor).
- hi_we_in  input  1  MTHI write.
- lo_we_in  input  1  MTLO write.
- flush_in  input  1  abort in-flight op (branch/exception squash).
- stall_out  output  1  hold PC, IF_ID and ID_EX.
- busy_out  output  1  state is BUSY.
- done_out  output  1  one-cycle pulse, HI/LO just updated by an op.
- div_by_zero_out  output  1  pulses with done_out when a DIV/DIVU had rt==0.
- hi_out  output  DATA_W  HI register.
- lo_out  output  DATA_W  LO register.

Behaviour:
- Reset (async, rst_n low): state IDLE; hi_out=0; lo_out=0; done_out=0; div_by_zero_out=0; busy_out=0; internal counter/accumulators=0.
- States:
  - IDLE: start_in at edge -> BUSY; latch op, operand magnitudes (signed ops take abs value), result-sign flags, counter=0.
  - BUSY: one radix-2 iteration per cycle. Multiply: shift-add over a 2*DATA_W product. Divide: restoring, one quotient bit per cycle. Counter increments each cycle; at counter==DATA_W-1, write HI/LO and go to DONE.
  - DONE: done_out=1 for exactly this cycle. start_in -> BUSY (back-to-back); else -> IDLE.
- Latency: start sampled at edge E0; HI/LO valid after edge E32; done_out high during the cycle following E32.
- stall_out = (state==BUSY) | (start_in & state!=BUSY). start_in during BUSY is ignored (the pipeline is stalled, so the same op is still presented).
- Sign rules:
  - MULT: negate the 64-bit product if the signs differ.
  - DIV: quotient negated if the signs differ; remainder takes the dividend's sign.
  - MULTU/DIVU: no correction.
  - HI = product[63:32] / remainder; LO = product[31:0] / quotient.
- Divide by zero: run the full latency; LO=FFFFFFFF, HI=rs raw, no sign correction; div_by_zero_out pulses with done_out.
- Overflow: DIV 80000000 / FFFFFFFF gives LO=80000000, HI=00000000, no flag.
- MTHI/MTLO: honoured only in IDLE or DONE, writing Read_Data_1_in on that edge. In DONE, the MT write overrides the op result for that register. Ignored during BUSY.
- flush_in: highest priority after reset. From any state -> IDLE at the next edge; HI/LO unchanged; done_out=0; a start_in in the same cycle is dropped.
- Reset asserted mid-operation clears everything immediately; no result is written.

Test Plan:
- Reset, then MULT rs=FFFFFFFD, rt=00000005 -> stall_out high for 33 cycles from start; done_out after E32; HI=FFFFFFFF, LO=FFFFFFF1.
- MULTU rs=rt=FFFFFFFF -> HI=FFFFFFFE, LO=00000001. Then DIV rs=FFFFFFF9, rt=00000002 started in DONE (back-to-back) -> LO=FFFFFFFD, HI=FFFFFFFF, with no IDLE gap.
- DIVU rs=00000064, rt=0 -> LO=FFFFFFFF, HI=00000064, div_by_zero_out=1 with done_out. DIV rs=80000000, rt=FFFFFFFF -> LO=80000000, HI=0.
- Preload HI=11111111 via MTHI and LO=22222222 via MTLO. Start DIVU, assert flush_in at cycle 10 -> IDLE next edge, HI/LO still 11111111/22222222, no done_out.
- Start MULTU, drop rst_n at cycle 5 -> all outputs 0 asynchronously. Also check that lo_we_in in the DONE cycle overrides LO while HI takes the op result.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit with HI/LO.
// Radix-2 shift-add multiply, restoring divide.
module ex_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_in,
  input  logic [1:0]        op_in,
  input  logic [DATA_W-1:0] Read_Data_1_in,
  input  logic [DATA_W-1:0] Read_Data_2_in,
  input  logic              hi_we_in,
  input  logic              lo_we_in,
  input  logic              flush_in,
  output logic              stall_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              div_by_zero_out,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  localparam int W  = DATA_W;
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          is_div_q;
  logic          neg_p_q;
  logic          neg_r_q;
  logic          dz_q;
  logic [W-1:0]  rs_q;
  logic [W-1:0]  opd_q;
  logic [2*W-1:0] acc_q;
  logic [W-1:0]  hi_q, lo_q;

  logic          sgn, a_neg, b_neg, is_div_in;
  logic [W-1:0]  a_mag, b_mag;
  logic          busy, last, take;

  assign is_div_in = op_in[1];
  assign sgn   = ~op_in[0];
  assign a_neg = sgn & Read_Data_1_in[W-1];
  assign b_neg = sgn & Read_Data_2_in[W-1];
  assign a_mag = a_neg ? -Read_Data_1_in : Read_Data_1_in;
  assign b_mag = b_neg ? -Read_Data_2_in : Read_Data_2_in;

  assign busy = (state_q == BUSY);
  assign last = busy & (cnt_q == LAST);
  assign take = ~busy & start_in;

  // acc holds {upper, multiplier} or {remainder, dividend/quotient}
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_nxt;
  logic [W:0]     div_t, div_rem;
  logic           div_ge;
  logic [2*W-1:0] div_nxt;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   q_s, r_s;
  logic [W-1:0]   res_hi, res_lo;

  assign mul_sum = {1'b0, acc_q[2*W-1:W]}
                 + (acc_q[0] ? {1'b0, opd_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[W-1:1]};

  assign div_t   = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_ge  = div_t >= {1'b0, opd_q};
  assign div_rem = div_ge ? div_t - {1'b0, opd_q} : div_t;
  assign div_nxt = {div_rem[W-1:0], acc_q[W-2:0], div_ge};

  assign prod_s = neg_p_q ? -mul_nxt : mul_nxt;
  assign q_s = neg_p_q ? -div_nxt[W-1:0] : div_nxt[W-1:0];
  assign r_s = neg_r_q ? -div_nxt[2*W-1:W] : div_nxt[2*W-1:W];

  always_comb begin
    res_hi = prod_s[2*W-1:W];
    res_lo = prod_s[W-1:0];
    unique case (1'b1)
      is_div_q & dz_q: begin
        res_hi = rs_q;
        res_lo = '1;
      end
      is_div_q & ~dz_q: begin
        res_hi = r_s;
        res_lo = q_s;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_in) state_d = BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    state_d = start_in ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_in) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      rs_q     <= '0;
      opd_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q <= state_d;
      if (!flush_in) begin
        if (busy) begin
          acc_q <= is_div_q ? div_nxt : mul_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end
        if (take) begin
          is_div_q <= is_div_in;
          neg_p_q  <= a_neg ^ b_neg;
          neg_r_q  <= a_neg;
          dz_q     <= is_div_in & (Read_Data_2_in == '0);
          rs_q     <= Read_Data_1_in;
          opd_q    <= is_div_in ? b_mag : a_mag;
          acc_q    <= {{W{1'b0}}, is_div_in ? a_mag : b_mag};
          cnt_q    <= '0;
        end
        if (!busy && hi_we_in) hi_q <= Read_Data_1_in;
        if (!busy && lo_we_in) lo_q <= Read_Data_1_in;
      end
    end
  end

  assign stall_out       = busy | take;
  assign busy_out        = busy;
  assign done_out        = (state_q == DONE);
  assign div_by_zero_out = done_out & dz_q;
  assign hi_out          = hi_q;
  assign lo_out          = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit.
// Expected HI/LO are queued at launch and checked at done_out.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start_in;
  logic [1:0]  op_in;
  logic [31:0] rd1, rd2;
  logic        hi_we_in, lo_we_in, flush_in;
  logic        stall_out, busy_out, done_out, div_by_zero_out;
  logic [31:0] hi_out, lo_out;

  ex_muldiv_unit #(.DATA_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_in        (start_in),
    .op_in           (op_in),
    .Read_Data_1_in  (rd1),
    .Read_Data_2_in  (rd2),
    .hi_we_in        (hi_we_in),
    .lo_we_in        (lo_we_in),
    .flush_in        (flush_in),
    .stall_out       (stall_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .div_by_zero_out (div_by_zero_out),
    .hi_out          (hi_out),
    .lo_out          (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l,
                      input logic d);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.dz = d;
    sb.push_back(e);
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    op_in    = op;
    rd1      = a;
    rd2      = b;
    start_in = 1'b1;
    @(posedge clk);
    #1;
    start_in = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat,
                           output int stl);
    bit   got;
    exp_t e;
    got = 0;
    lat = 0;
    stl = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (done_out) got = 1;
      else if (stall_out) stl++;
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    if (got) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk({tag, "_hi"}, 64'(hi_out), 64'(e.hi));
        chk({tag, "_lo"}, 64'(lo_out), 64'(e.lo));
        chk({tag, "_dz"}, 64'(div_by_zero_out), 64'(e.dz));
      end
    end
  endtask

  initial begin
    int lat, stl;
    bit saw;
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    start_in = 1'b0;
    op_in    = 2'b00;
    rd1      = '0;
    rd2      = '0;
    hi_we_in = 1'b0;
    lo_we_in = 1'b0;
    flush_in = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_done", 64'(done_out), 64'd0);
    chk("rst_dz", 64'(div_by_zero_out), 64'd0);
    chk("rst_stall", 64'(stall_out), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MULT -3 * 5
    push(32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    op_in    = 2'b00;
    rd1      = 32'hFFFFFFFD;
    rd2      = 32'h00000005;
    start_in = 1'b1;
    @(negedge clk);
    chk("mult_stall_start", 64'(stall_out), 64'd1);
    @(posedge clk);
    #1;
    start_in = 1'b0;
    wait_done("mult", lat, stl);
    chk("mult_latency", 64'(lat), 64'd33);
    chk("mult_stall_cycles", 64'(stl + 1), 64'd33);
    chk("mult_done_nostall", 64'(stall_out), 64'd0);
    @(posedge clk);
    #1;
    chk("mult_idle_after", 64'(done_out), 64'd0);

    // MULTU max*max, then DIV back-to-back from DONE
    push(32'hFFFFFFFE, 32'h00000001, 1'b0);
    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu", lat, stl);
    push(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    op_in    = 2'b10;
    rd1      = 32'hFFFFFFF9;
    rd2      = 32'h00000002;
    start_in = 1'b1;
    #1;
    chk("b2b_stall_in_done", 64'(stall_out), 64'd1);
    @(posedge clk);
    #1;
    start_in = 1'b0;
    chk("b2b_busy_no_gap", 64'(busy_out), 64'd1);
    wait_done("div_b2b", lat, stl);
    chk("div_b2b_latency", 64'(lat), 64'd33);

    // DIVU by zero
    push(32'h00000064, 32'hFFFFFFFF, 1'b1);
    launch(2'b11, 32'h00000064, 32'h00000000);
    wait_done("divu_zero", lat, stl);
    chk("divu_zero_latency", 64'(lat), 64'd33);

    // DIV overflow
    push(32'h00000000, 32'h80000000, 1'b0);
    @(posedge clk);
    #1;
    launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf", lat, stl);

    // MTHI/MTLO preload, then flushed DIVU
    @(posedge clk);
    #1;
    rd1      = 32'h11111111;
    hi_we_in = 1'b1;
    @(posedge clk);
    #1;
    hi_we_in = 1'b0;
    rd1      = 32'h22222222;
    lo_we_in = 1'b1;
    @(posedge clk);
    #1;
    lo_we_in = 1'b0;
    chk("mthi", 64'(hi_out), 64'h11111111);
    chk("mtlo", 64'(lo_out), 64'h22222222);
    launch(2'b11, 32'h00001234, 32'h00000007);
    repeat (9) @(posedge clk);
    #1;
    chk("flush_pre_busy", 64'(busy_out), 64'd1);
    flush_in = 1'b1;
    @(posedge clk);
    #1;
    flush_in = 1'b0;
    chk("flush_busy", 64'(busy_out), 64'd0);
    chk("flush_hi", 64'(hi_out), 64'h11111111);
    chk("flush_lo", 64'(lo_out), 64'h22222222);
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_out) saw = 1;
    end
    chk("flush_no_done", 64'(saw), 64'd0);
    chk("flush_hi_late", 64'(hi_out), 64'h11111111);

    // MTLO during DONE overrides LO; HI keeps op result
    push(32'h00000000, 32'h0000000C, 1'b0);
    @(posedge clk);
    #1;
    launch(2'b01, 32'h00000003, 32'h00000004);
    wait_done("mtlo_done", lat, stl);
    rd1      = 32'hABCDABCD;
    lo_we_in = 1'b1;
    @(posedge clk);
    #1;
    lo_we_in = 1'b0;
    chk("mtlo_done_lo", 64'(lo_out), 64'hABCDABCD);
    chk("mtlo_done_hi", 64'(hi_out), 64'h00000000);
    chk("mtlo_done_idle", 64'(busy_out | done_out), 64'd0);

    // Async reset mid-operation
    launch(2'b01, 32'h00000009, 32'h00000009);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 64'(busy_out), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy_out), 64'd0);
    chk("arst_stall", 64'(stall_out), 64'd0);
    chk("arst_done", 64'(done_out), 64'd0);
    chk("arst_hi", 64'(hi_out), 64'd0);
    chk("arst_lo", 64'(lo_out), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_out) saw = 1;
    end
    chk("arst_no_done", 64'(saw), 64'd0);
    chk("arst_lo_late", 64'(lo_out), 64'h0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
